// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer that owns the program counter. It issues one
//   request at a time to instruction memory (req/gnt, then a single rvalid
//   response), advances the PC by 4 on each granted request or redirects it on
//   a jump, and hands each fetched word to decode through a one-entry
//   valid/ready output register.
//
//   Sequence: FETCH -> WAIT_RSP -> OUT -> FETCH. A jump that lands while a
//   request is in flight marks that request as killed; its response is
//   swallowed and never reaches decode.
//
// Ports
//   clk            in   1   clock, all state updates on posedge
//   rst_n          in   1   synchronous active-low reset
//   jump_en_i      in   1   redirect request from execute (1-cycle pulse)
//   jump_addr_i    in   32  redirect target, bits [1:0] ignored
//   imem_req_o     out  1   fetch request to IMEM
//   imem_addr_o    out  32  fetch address (current PC)
//   imem_gnt_i     in   1   IMEM accepted the request this cycle
//   imem_rvalid_i  in   1   IMEM read data valid
//   imem_rdata_i   in   32  IMEM read data
//   inst_valid_o   out  1   instruction word valid to decode
//   inst_o         out  32  instruction word
//   inst_addr_o    out  32  address the instruction was fetched from
//   inst_ready_i   in   1   decode accepts inst_o this cycle
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ready_i
);

   typedef enum logic [1:0] {
      ST_FETCH    = 2'd0,
      ST_WAIT_RSP = 2'd1,
      ST_OUT      = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        kill_q, kill_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic [31:0] jump_tgt;

   // Targets are always word aligned; the low address bits are dropped.
   assign jump_tgt = {jump_addr_i[31:2], 2'b00};

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      kill_d       = kill_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;

      case (state_q)
         ST_FETCH: begin
            if (imem_gnt_i) begin
               // The request is granted even when a jump arrives with it; the
               // response is then killed and the PC takes the target.
               req_addr_d = pc_q;
               kill_d     = jump_en_i;
               pc_d       = jump_en_i ? jump_tgt : pc_q + 32'd4;
               state_d    = ST_WAIT_RSP;
            end else if (jump_en_i) begin
               pc_d = jump_tgt;
            end
         end

         ST_WAIT_RSP: begin
            if (imem_rvalid_i) begin
               kill_d = 1'b0;
               if (kill_q || jump_en_i) begin
                  state_d = ST_FETCH;
               end else begin
                  inst_d       = imem_rdata_i;
                  inst_addr_d  = req_addr_q;
                  inst_valid_d = 1'b1;
                  state_d      = ST_OUT;
               end
            end else if (jump_en_i) begin
               // Only one request can be outstanding, so a single flag is
               // enough; repeated jumps just keep it set.
               kill_d = 1'b1;
            end
            if (jump_en_i) begin
               pc_d = jump_tgt;
            end
         end

         ST_OUT: begin
            // A jump drops the held word; if decode accepted it in the same
            // cycle it has already been consumed.
            if (jump_en_i || inst_ready_i) begin
               inst_valid_d = 1'b0;
               state_d      = ST_FETCH;
            end
            if (jump_en_i) begin
               pc_d = jump_tgt;
            end
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: reset is synchronous here (sampled only on the clock edge), and all
   // sequential state uses non-blocking assignments so every register sees the
   // pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         req_addr_q   <= 32'h0;
         kill_q       <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_addr_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         kill_q       <= kill_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_addr_q  <= inst_addr_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The request is gated by rst_n so it is never raised while reset is held,
   // even though the state register itself only updates on the edge.
   assign imem_req_o   = rst_n && (state_q == ST_FETCH);
   assign imem_addr_o  = pc_q;
   assign inst_valid_o = inst_valid_q;
   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Scoreboard bench for fetch_ctrl. A stimulus process plays IMEM, execute and
//   decode; a transaction-level reference model predicts which addresses get
//   fetched and which responses reach decode, pushing them into queues. A
//   separate monitor compares the DUT against those queues and against the
//   per-cycle request/valid expectations.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] jump_addr = 32'h0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        ready = 1'b0;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_addr;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .jump_en_i     (jump_en),
      .jump_addr_i   (jump_addr),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (gnt),
      .imem_rvalid_i (rvalid),
      .imem_rdata_i  (rdata),
      .inst_valid_o  (inst_valid),
      .inst_o        (inst),
      .inst_addr_o   (inst_addr),
      .inst_ready_i  (ready)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------------------------
   // Reference model (transaction level)
   //   m_pc       address of the next fetch
   //   m_pending  a granted request is waiting for its response
   //   m_doomed   that pending response has been overtaken by a jump
   //   m_holding  decode currently has a word offered to it
   // --------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } inst_t;

   logic [31:0] exp_fetch_q[$];
   inst_t       exp_inst_q[$];

   logic [31:0] m_pc = RESET_PC;
   logic [31:0] m_req_addr = 32'h0;
   bit          m_pending = 1'b0;
   bit          m_doomed = 1'b0;
   bit          m_holding = 1'b0;
   bit          m_out_zero = 1'b1;
   int          n_grants = 0;

   // Expectations for the cycle currently being driven (before the edge).
   bit          exp_req_now = 1'b0;
   logic [31:0] exp_addr_now = 32'h0;
   bit          exp_valid_now = 1'b0;
   bit          exp_zero_now = 1'b0;

   // One clock of stimulus. gnt is only offered while the model expects a
   // request; rvalid only while a response is owed, unless a stray one is
   // asked for on purpose.
   task automatic step(input bit r, input bit g, input bit rv, input bit rdy,
                       input bit j, input logic [31:0] ja, input bit stray);
      logic [31:0] tgt;
      bit          fetching;
      @(negedge clk);
      fetching  = !m_pending && !m_holding;
      rst_n     = r;
      gnt       = g && fetching && r;
      rvalid    = (rv && m_pending) || stray;
      rdata     = $urandom();
      ready     = rdy;
      jump_en   = j;
      jump_addr = ja;

      exp_req_now   = r && fetching;
      exp_addr_now  = m_pc;
      exp_valid_now = m_holding;
      exp_zero_now  = m_out_zero;

      tgt = ja & 32'hFFFF_FFFC;
      if (!r) begin
         m_pc       = RESET_PC;
         m_pending  = 1'b0;
         m_doomed   = 1'b0;
         m_holding  = 1'b0;
         m_out_zero = 1'b1;
         exp_inst_q.delete();
      end else if (m_holding) begin
         if (j) begin
            if (!rdy) void'(exp_inst_q.pop_front());
            m_holding = 1'b0;
            m_pc      = tgt;
         end else if (rdy) begin
            m_holding = 1'b0;
         end
      end else if (m_pending) begin
         if (rvalid) begin
            if (!m_doomed && !j) begin
               exp_inst_q.push_back(inst_t'{addr: m_req_addr, data: rdata});
               m_holding  = 1'b1;
               m_out_zero = 1'b0;
            end
            m_pending = 1'b0;
            m_doomed  = 1'b0;
         end else if (j) begin
            m_doomed = 1'b1;
         end
         if (j) m_pc = tgt;
      end else begin
         if (gnt) begin
            exp_fetch_q.push_back(m_pc);
            n_grants++;
            m_req_addr = m_pc;
            m_pending  = 1'b1;
            m_doomed   = j;
            m_pc       = j ? tgt : m_pc + 32'd4;
         end else if (j) begin
            m_pc = tgt;
         end
      end
   endtask

   task automatic normal(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 1, 1, 0, 32'h0, 0);
   endtask

   // --------------------------------------------------------------------------
   // Monitor: samples 1 time unit after the stimulus has driven the cycle.
   // --------------------------------------------------------------------------
   initial begin
      bit          prev_hold;
      logic [31:0] prev_inst;
      logic [31:0] prev_addr;
      inst_t       e;
      prev_hold = 1'b0;
      prev_inst = 32'h0;
      prev_addr = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         check("imem_req", imem_req, exp_req_now);
         if (exp_req_now) check("imem_addr", imem_addr, exp_addr_now);
         check("inst_valid", inst_valid, exp_valid_now);
         if (exp_zero_now) begin
            check("inst_zero", inst, 32'h0);
            check("inst_addr_zero", inst_addr, 32'h0);
         end
         if (prev_hold) begin
            check("hold_inst", inst, prev_inst);
            check("hold_inst_addr", inst_addr, prev_addr);
         end
         if (imem_req && gnt) begin
            if (exp_fetch_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_grant: got grant at %h, expected no request", imem_addr);
            end else begin
               check("fetch_addr", imem_addr, exp_fetch_q.pop_front());
            end
         end
         if (rst_n && inst_valid && ready) begin
            if (exp_inst_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_inst: got %h from %h, expected no instruction", inst, inst_addr);
            end else begin
               e = exp_inst_q.pop_front();
               check("inst_data", inst, e.data);
               check("inst_addr", inst_addr, e.addr);
            end
         end
         prev_hold = rst_n && inst_valid && !ready && !jump_en;
         prev_inst = inst;
         prev_addr = inst_addr;
      end
   end

   // --------------------------------------------------------------------------
   // Stimulus
   // --------------------------------------------------------------------------
   initial begin
      // Reset, then sequential fetch 0,4,8,C with immediate gnt/rvalid/ready.
      step(0, 0, 0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0);
      normal(12);

      // Decode stalls for 5 cycles while a word is offered.
      step(1, 1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 1, 0, 32'h0, 0);
      normal(6);

      // Jump to 0x103 while waiting on the response for address 8.
      step(0, 0, 0, 0, 0, 32'h0, 0);
      normal(6);
      step(1, 1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 1, 32'h0000_0103, 0);
      step(1, 0, 1, 0, 0, 32'h0, 0);
      normal(6);

      // Move to 0x10, then jump to 0x200 in the same cycle as the grant.
      step(1, 0, 0, 0, 1, 32'h0000_0010, 0);
      step(1, 1, 0, 0, 1, 32'h0000_0200, 0);
      step(1, 0, 1, 0, 0, 32'h0, 0);
      normal(6);

      // PC wrap from FFFF_FFFC to 0.
      step(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
      normal(6);

      // Jump while a word is offered: once with a handshake, once without.
      step(1, 1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 1, 0, 0, 32'h0, 0);
      step(1, 0, 0, 1, 1, 32'h0000_0040, 0);
      step(1, 1, 0, 0, 0, 32'h0, 0);
      step(1, 0, 1, 0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 1, 32'h0000_0080, 0);
      normal(6);

      // Reset during WAIT_RSP, then a late response arrives after reset.
      step(1, 1, 0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 0, 32'h0, 1);
      normal(6);

      // Randomized traffic, including stray rvalids and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         bit r, g, rv, rdy, j, stray;
         r     = ($urandom_range(0, 199) != 0);
         g     = ($urandom_range(0, 2) != 0);
         rv    = ($urandom_range(0, 1) != 0);
         rdy   = ($urandom_range(0, 9) < 7);
         j     = ($urandom_range(0, 9) == 0);
         stray = ($urandom_range(0, 19) == 0) && !m_pending;
         step(r, g, rv, rdy, j, $urandom(), stray);
      end

      #2;
      check("fetch_queue_drained", exp_fetch_q.size(), 32'd0);
      check("inst_queue_level", exp_inst_q.size(), m_holding ? 32'd1 : 32'd0);
      check("enough_grants", (n_grants >= 100) ? 32'd1 : 32'd0, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
